// File: rtl/hazard_ctrl_if.sv
// Pipeline <-> hazard controller signal bundle. The pipeline side is the master
// (drives hazard sources); the controller is the slave (drives stall/flush pins).
interface hazard_ctrl_if;
    logic [4:0] if_id_rs1_addr;
    logic [4:0] if_id_rs2_addr;
    logic       if_id_valid;
    logic [4:0] id_ex_rd_addr;
    logic       id_ex_mem_read;
    logic       id_ex_is_muldiv;
    logic       id_ex_valid;
    logic       ex_redirect;
    logic       mdu_done;
    logic       dmem_req;
    logic       dmem_ready;

    logic       pc_stall;
    logic       if_id_stall;
    logic       id_ex_stall;
    logic       ex_mem_stall;
    logic       if_id_flush;
    logic       id_ex_flush;
    logic       ex_mem_flush;
    logic       mem_wb_flush;
    logic       mdu_start;
    logic       pc_redirect;

    modport master (
        output if_id_rs1_addr, if_id_rs2_addr, if_id_valid,
               id_ex_rd_addr, id_ex_mem_read, id_ex_is_muldiv, id_ex_valid,
               ex_redirect, mdu_done, dmem_req, dmem_ready,
        input  pc_stall, if_id_stall, id_ex_stall, ex_mem_stall,
               if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush,
               mdu_start, pc_redirect
    );

    modport slave (
        input  if_id_rs1_addr, if_id_rs2_addr, if_id_valid,
               id_ex_rd_addr, id_ex_mem_read, id_ex_is_muldiv, id_ex_valid,
               ex_redirect, mdu_done, dmem_req, dmem_ready,
        output pc_stall, if_id_stall, id_ex_stall, ex_mem_stall,
               if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush,
               mdu_start, pc_redirect
    );
endinterface

// File: rtl/hazard_ctrl.sv
// Stall/flush scheduler for the 5-stage in-order pipeline.
// Optional performance counters are compiled in with HAZARD_PERF_CNT_EN.
module hazard_ctrl #(
    parameter int IMEM_LATENCY = 1,
    parameter int CNT_W        = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    hazard_ctrl_if.slave      hz
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0]  stall_cycles,
    output logic [CNT_W-1:0]  flush_events,
    output logic [CNT_W-1:0]  mdu_cycles
`endif
);

    typedef enum logic {RUN, MDU_WAIT} state_e;

    localparam logic [1:0] SHADOW_LOAD = 2'(IMEM_LATENCY);

    state_e     state_q, state_d;
    logic [1:0] shadow_cnt_q, shadow_cnt_d;
    logic       done_pend_q, done_pend_d;

    logic mem_wait, done_eff, mdu_busy, redirect_take, shadow_act;
    logic rs_match, load_use, start_mdu;

    always_comb begin
        mem_wait      = hz.dmem_req & ~hz.dmem_ready;
        // A done pulse swallowed by a memory freeze is replayed from the sticky flag.
        done_eff      = hz.mdu_done | done_pend_q;
        mdu_busy      = (state_q == MDU_WAIT) & ~done_eff;
        redirect_take = ~mem_wait & ~mdu_busy & hz.ex_redirect & hz.id_ex_valid;
        shadow_act    = shadow_cnt_q != 2'd0;
        rs_match      = (hz.id_ex_rd_addr == hz.if_id_rs1_addr) |
                        (hz.id_ex_rd_addr == hz.if_id_rs2_addr);
        load_use      = hz.id_ex_valid & hz.id_ex_mem_read & hz.if_id_valid &
                        (hz.id_ex_rd_addr != 5'd0) & rs_match;
        start_mdu     = (state_q == RUN) & hz.id_ex_valid & hz.id_ex_is_muldiv & ~mem_wait;
    end

    always_comb begin
        hz.pc_stall     = 1'b0;
        hz.if_id_stall  = 1'b0;
        hz.id_ex_stall  = 1'b0;
        hz.ex_mem_stall = 1'b0;
        hz.if_id_flush  = 1'b0;
        hz.id_ex_flush  = 1'b0;
        hz.ex_mem_flush = 1'b0;
        hz.mem_wb_flush = 1'b0;
        hz.pc_redirect  = 1'b0;
        hz.mdu_start    = 1'b0;
        if (!reset_n) begin
            hz.if_id_flush  = 1'b1;
            hz.id_ex_flush  = 1'b1;
            hz.ex_mem_flush = 1'b1;
            hz.mem_wb_flush = 1'b1;
        end else begin
            hz.mdu_start = start_mdu;
            if (mem_wait) begin
                hz.pc_stall     = 1'b1;
                hz.if_id_stall  = 1'b1;
                hz.id_ex_stall  = 1'b1;
                hz.ex_mem_stall = 1'b1;
                hz.mem_wb_flush = 1'b1;
            end else if (mdu_busy) begin
                hz.pc_stall     = 1'b1;
                hz.if_id_stall  = 1'b1;
                hz.id_ex_stall  = 1'b1;
                hz.ex_mem_flush = 1'b1;
            end else if (redirect_take) begin
                // The younger instruction in ID is killed, so any load-use stall is moot.
                hz.pc_redirect  = 1'b1;
                hz.if_id_flush  = 1'b1;
                hz.id_ex_flush  = 1'b1;
            end else if (shadow_act) begin
                hz.if_id_flush  = 1'b1;
            end else if (load_use) begin
                hz.pc_stall     = 1'b1;
                hz.if_id_stall  = 1'b1;
                hz.id_ex_flush  = 1'b1;
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        shadow_cnt_d = shadow_cnt_q;
        done_pend_d  = done_pend_q;
        if (mem_wait) begin
            if ((state_q == MDU_WAIT) && hz.mdu_done)
                done_pend_d = 1'b1;
        end else begin
            done_pend_d = 1'b0;
            unique case (state_q)
                RUN:      if (start_mdu) state_d = MDU_WAIT;
                MDU_WAIT: if (done_eff)  state_d = RUN;
                default:  state_d = RUN;
            endcase
            if (redirect_take)
                shadow_cnt_d = SHADOW_LOAD;
            else if (!mdu_busy && shadow_act)
                shadow_cnt_d = shadow_cnt_q - 2'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= RUN;
            shadow_cnt_q <= 2'd0;
            done_pend_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            shadow_cnt_q <= shadow_cnt_d;
            done_pend_q  <= done_pend_d;
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cycles_q, flush_events_q, mdu_cycles_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stall_cycles_q <= '0;
            flush_events_q <= '0;
            mdu_cycles_q   <= '0;
        end else begin
            if (hz.pc_stall)           stall_cycles_q <= stall_cycles_q + CNT_W'(1);
            if (redirect_take)         flush_events_q <= flush_events_q + CNT_W'(1);
            if (state_q == MDU_WAIT)   mdu_cycles_q   <= mdu_cycles_q + CNT_W'(1);
        end
    end

    assign stall_cycles = stall_cycles_q;
    assign flush_events = flush_events_q;
    assign mdu_cycles   = mdu_cycles_q;
`endif

endmodule
